// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs RV32I instruction fields into 32-bit words and
// streams them, one word per cycle, into instruction memory starting at BASE_ADDR.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               pulse: clear pointer/count/error and enter LOAD
//   i_valid/o_ready       field-beat handshake (o_ready is combinational)
//   i_last                final instruction of the program
//   i_opcode..i_imm       instruction fields, imm unencoded and signed
//   o_mem_we/addr/wdata/be  registered instruction-memory write port
//   o_busy, o_done        in LOAD / pulse with the final write
//   o_error, o_err_code   sticky error and its cause (01 field, 10 imm, 11 overflow)
//   o_count               words written since i_start
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_last,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic              i_funct7b5,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [1:0]        o_err_code,
  output logic [ADDR_W:0]   o_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] count;
  logic [31:0]      enc_word;
  logic [11:0]      i_field;
  logic             op_err;
  logic             imm_err;
  logic             fits12;
  logic             fits13;
  logic             fits21;
  logic [1:0]       beat_code;
  logic             accept;
  logic             write;

  // Signed-range checks: all bits above the sign bit must replicate it.
  assign fits12 = (i_imm[31:11] == '0) || (i_imm[31:11] == '1);
  assign fits13 = (i_imm[31:12] == '0) || (i_imm[31:12] == '1);
  assign fits21 = (i_imm[31:20] == '0) || (i_imm[31:20] == '1);

  // Field packing and legality check per instruction format.
  always_comb begin
    enc_word = '0;
    op_err   = 1'b0;
    imm_err  = 1'b0;
    i_field  = i_imm[11:0];
    case (i_opcode)
      OP_R: begin
        enc_word = {1'b0, i_funct7b5, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      OP_ALUI: begin
        // Shift-immediates carry funct7b5 (SRAI) above a 5-bit shamt.
        if (i_funct3 == 3'b001 || i_funct3 == 3'b101) begin
          i_field = {1'b0, i_funct7b5, 5'b0, i_imm[4:0]};
        end
        enc_word = {i_field, i_rs1, i_funct3, i_rd, i_opcode};
        imm_err  = ~fits12;
      end
      OP_LOAD: begin
        enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        op_err   = i_funct3 inside {3'b011, 3'b110, 3'b111};
        imm_err  = ~fits12;
      end
      OP_JALR: begin
        enc_word = {i_imm[11:0], i_rs1, 3'b000, i_rd, i_opcode};
        imm_err  = ~fits12;
      end
      OP_STORE: begin
        enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        op_err   = i_funct3 > 3'b010;
        imm_err  = ~fits12;
      end
      OP_BRANCH: begin
        enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                    i_imm[4:1], i_imm[11], i_opcode};
        op_err   = i_funct3 inside {3'b010, 3'b011};
        imm_err  = ~fits13 | i_imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        enc_word = {i_imm[31:12], i_rd, i_opcode};
      end
      OP_JAL: begin
        enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        imm_err  = ~fits21 | i_imm[0];
      end
      default: begin
        op_err = 1'b1;
      end
    endcase
  end

  // Error priority: field legality, then immediate, then overflow.
  assign beat_code = op_err           ? 2'b01 :
                     imm_err          ? 2'b10 :
                     (count == DEPTH) ? 2'b11 : 2'b00;

  assign o_ready = (state == S_LOAD) & ~i_start;
  assign accept  = i_valid & o_ready;
  assign write   = accept & (beat_code == 2'b00);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; i_start wins from any state.
  always_comb begin
    state_d = state;
    if (i_start) begin
      state_d = S_LOAD;
    end else if (accept) begin
      if (beat_code != 2'b00) begin
        state_d = S_ERR;
      end else if (i_last) begin
        state_d = S_IDLE;
      end
    end
  end

  // Write port, word counter and sticky error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_err_code  <= 2'b00;
      count       <= '0;
    end else begin
      o_mem_we <= write;
      o_done   <= write & i_last;
      if (write) begin
        o_mem_addr  <= BASE_ADDR + (32'(count) << 2);
        o_mem_wdata <= enc_word;
      end
      if (i_start) begin
        count      <= '0;
        o_error    <= 1'b0;
        o_err_code <= 2'b00;
      end else if (write) begin
        count <= count + CNT_W'(1);
      end else if (accept) begin
        o_error    <= 1'b1;
        o_err_code <= beat_code;
      end
    end
  end

  assign o_mem_be = {4{o_mem_we}};
  assign o_busy   = (state == S_LOAD);
  assign o_count  = count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed program loads plus randomized field
// beats; expected writes go through a scoreboard queue consumed by a monitor.
module tb_instr_encoder_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic        last = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [AW:0] count;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .o_ready(ready),
    .i_last(last), .i_opcode(opcode), .i_funct3(funct3), .i_funct7b5(funct7b5),
    .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
    .o_busy(busy), .o_done(done), .o_error(error), .o_err_code(err_code), .o_count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic        done;
    int unsigned cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state: 0 idle, 1 load, 2 error.
  int          m_state = 0;
  int unsigned m_cnt   = 0;
  logic        m_err   = 1'b0;
  logic [1:0]  m_code  = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: returns {code, word} from the format rules with plain arithmetic.
  function automatic logic [33:0] ref_encode(input logic [6:0] op_i, input logic [2:0] f3_i,
      input logic f7_i, input logic [4:0] rd_i, input logic [4:0] rs1_i, input logic [4:0] rs2_i,
      input logic [31:0] imm_i);
    int unsigned o, f, g, d, a, b, u, w, top;
    int          s;
    logic [1:0]  code;
    o = 32'(op_i); f = 32'(f3_i); g = 32'(f7_i);
    d = 32'(rd_i); a = 32'(rs1_i); b = 32'(rs2_i);
    u = imm_i; s = $signed(imm_i);
    code = 2'b00; w = 0;
    case (o)
      32'h33: w = (g << 30) | (b << 20) | (a << 15) | (f << 12) | (d << 7) | o;
      32'h13, 32'h03, 32'h67: begin
        if (o == 32'h03 && (f == 3 || f == 6 || f == 7)) code = 2'b01;
        else if (s < -2048 || s > 2047) code = 2'b10;
        top = u % 4096;
        if (o == 32'h13 && (f == 1 || f == 5)) top = g * 1024 + (u % 32);
        if (o == 32'h67) f = 0;
        w = (top << 20) | (a << 15) | (f << 12) | (d << 7) | o;
      end
      32'h23: begin
        if (f > 2) code = 2'b01;
        else if (s < -2048 || s > 2047) code = 2'b10;
        w = (((u / 32) % 128) << 25) | (b << 20) | (a << 15) | (f << 12) | ((u % 32) << 7) | o;
      end
      32'h63: begin
        if (f == 2 || f == 3) code = 2'b01;
        else if (s < -4096 || s > 4095 || (u % 2) != 0) code = 2'b10;
        w = (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | (b << 20) | (a << 15) |
            (f << 12) | (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7) | o;
      end
      32'h37, 32'h17: w = (u / 4096) * 4096 + (d << 7) + o;
      32'h6F: begin
        if (s < -1048576 || s > 1048575 || (u % 2) != 0) code = 2'b10;
        w = (((u / 1048576) % 2) << 31) | (((u / 2) % 1024) << 21) | (((u / 2048) % 2) << 20) |
            (((u / 4096) % 256) << 12) | (d << 7) | o;
      end
      default: code = 2'b01;
    endcase
    return {code, w};
  endfunction

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_we) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.word);
          chk("wr_be", 32'(mem_be), 32'h0000_000F);
          chk("wr_done", 32'(done), 32'(e.done));
          chk("wr_count", 32'(count), e.cnt);
        end
      end else if (done) begin
        n_checks++; n_fail++;
        $display("FAIL done_alone: got done=1 expected done only with a write");
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    valid = 1'b0; last = 1'b0; start = 1'b1;
    #1 chk("ready_in_start", 32'(ready), 32'h0);
    @(posedge clk);
    m_state = 1; m_cnt = 0; m_err = 1'b0; m_code = 2'b00;
    #1;
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_error", 32'(error), 32'h0);
    chk("start_count", 32'(count), 32'h0);
  endtask

  // One field beat; xw != 0 supplies a hand-computed expected word.
  task automatic beat(input logic [6:0] op_i, input logic [2:0] f3_i, input logic f7_i,
      input logic [4:0] rd_i, input logic [4:0] rs1_i, input logic [4:0] rs2_i,
      input logic [31:0] imm_i, input logic last_i, input logic [31:0] xw);
    logic [33:0] r;
    logic [1:0]  code;
    logic        rdy;
    exp_t        e;
    @(negedge clk);
    start = 1'b0; valid = 1'b1; last = last_i;
    opcode = op_i; funct3 = f3_i; funct7b5 = f7_i; rd = rd_i; rs1 = rs1_i; rs2 = rs2_i; imm = imm_i;
    #1;
    rdy = (m_state == 1);
    chk("ready", 32'(ready), 32'(rdy));
    if (rdy) begin
      r = ref_encode(op_i, f3_i, f7_i, rd_i, rs1_i, rs2_i, imm_i);
      code = r[33:32];
      if (code == 2'b00 && m_cnt == DEPTH) code = 2'b11;
      if (code != 2'b00) begin
        m_state = 2; m_err = 1'b1; m_code = code;
      end else begin
        e.addr = BASE + 32'(4 * m_cnt);
        e.word = (xw != 0) ? xw : r[31:0];
        e.done = last_i;
        e.cnt  = m_cnt + 1;
        sb.push_back(e);
        m_cnt++;
        if (last_i) m_state = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("error", 32'(error), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("busy", 32'(busy), 32'(m_state == 1));
    chk("count", 32'(count), m_cnt);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid = 1'b0; last = 1'b0; start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_beat(input logic last_i);
    logic [6:0]  ops[9];
    logic [6:0]  op;
    logic [31:0] v;
    int          mode;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    op = ($urandom_range(0, 11) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
    mode = $urandom_range(0, 3);
    case (mode)
      0: v = 32'(int'($urandom_range(0, 4095)) - 2048);
      1: v = 32'(int'($urandom_range(0, 10000)) - 5000);
      2: v = $urandom;
      default: v = 32'(int'($urandom_range(0, 4194303)) - 2097152);
    endcase
    if ($urandom_range(0, 3) != 0) v[0] = 1'b0;
    beat(op, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), v, last_i, 32'h0);
  endtask

  initial begin
    #1;
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_error", {30'h0, err_code}, 32'(error));

    // Directed program: ADD, ADDI, SW, SRAI, BEQ, JAL(last).
    do_start();
    beat(7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3);
    beat(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00093);
    beat(7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020A423);
    beat(7'h13, 3'd5, 1'b1, 5'd5, 5'd5, 5'd0, 32'd3, 1'b0, 32'h4032D293);
    beat(7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    beat(7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h001000EF);
    idle(2);

    // Bad opcode, beat refused while in error, restart, misaligned branch.
    do_start();
    beat(7'h7F, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 32'h0);
    beat(7'h33, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0);
    do_start();
    beat(7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3, 1'b0, 32'h0);
    do_start();
    beat(7'h03, 3'd6, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4, 1'b0, 32'h0);
    do_start();
    beat(7'h13, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd2048, 1'b0, 32'h0);
    do_start();
    beat(7'h37, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5FFF, 1'b1, 32'h123453B7);
    idle(1);

    // Fill to DEPTH, then one more beat overflows.
    do_start();
    for (int i = 0; i < DEPTH; i++) beat(7'h13, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0, 32'h0);
    beat(7'h13, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0, 32'h0);
    idle(1);

    // Async reset with a write in flight.
    do_start();
    beat(7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3);
    beat(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00093);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 32'(mem_we), 32'h0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_data", mem_wdata, 32'h0);
    chk("arst_be", 32'(mem_be), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_ready", 32'(ready), 32'h0);
    chk("arst_count", 32'(count), 32'h0);
    sb.delete();
    m_state = 0; m_cnt = 0; m_err = 1'b0; m_code = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    beat(7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0);
    do_start();
    beat(7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);

    // Randomized programs.
    for (int p = 0; p < 40; p++) begin
      int n;
      do_start();
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) rand_beat(k == n - 1);
    end
    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of test expected completion");
    $fatal(1);
  end

endmodule
